hier_value_checker: RTL and testbench

Sequential self-checking monitor for the behavioural-simulator example benches. Test drivers present observed values, such as hierarchical nets read after a settle delay, together with the value they should have. This block compares each pair, counts passes and failures, latches the first failing index and signals completion. It is the reading end of the driver/expect flow the example benches use.

---
 rtl/hier_value_checker_pkg.sv | 17 +
 rtl/hier_sat_counter.sv | 17 +
 rtl/hier_value_checker.sv | 105 ++++++++++
 tb/tb_hier_value_checker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hier_value_checker_pkg.sv
// Shared types and helpers for the hier_value_checker monitor.
package hier_value_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] NO_FAIL = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hier_sat_counter.sv
// 8-bit saturating counter with synchronous clear and increment enable.
module hier_sat_counter
  import hier_value_checker_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) count <= 8'd0;
    else if (inc)     count <= sat_inc(count);
  end

endmodule

// File: rtl/hier_value_checker.sv
// Sample/expect comparator that tallies passes and fails over one run.
// Optional HIER_CHK_REPORT_EN adds $write reporting; outputs are unaffected.
module hier_value_checker
  import hier_value_checker_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NUM_CHECKS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [WIDTH-1:0] sample_data,
  input  logic [WIDTH-1:0] expect_data,
  output logic [7:0]       pass_count,
  output logic [7:0]       fail_count,
  output logic [7:0]       first_fail_idx,
  output logic             done,
  output logic             pass
);

  localparam logic [7:0] LAST = 8'(NUM_CHECKS);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sample_q, expect_q;
  logic [7:0]       idx;
  logic             accept, in_cmp, match, last;

  assign sample_ready = (state == RUN);
  assign done         = (state == DONE);
  assign pass         = done && (fail_count == 8'd0);

  // start wins over a coincident handshake: that pair is discarded
  assign accept = sample_valid && sample_ready && !start;
  assign in_cmp = (state == CMP) && !start;
  assign last   = (idx + 8'd1) == LAST;

  // Any unknown bit on either side is a mismatch, even X against X
  assign match = (sample_q === expect_q) && !$isunknown(sample_q) && !$isunknown(expect_q);

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = RUN;
    else begin
      case (state)
        RUN:     if (accept) state_nxt = CMP;
        CMP:     state_nxt = last ? DONE : RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= 8'd0;
      first_fail_idx <= NO_FAIL;
      sample_q       <= '0;
      expect_q       <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        idx            <= 8'd0;
        first_fail_idx <= NO_FAIL;
      end else if (in_cmp) begin
        idx <= idx + 8'd1;
        if (!match && first_fail_idx == NO_FAIL) first_fail_idx <= idx;
      end
      if (accept) begin
        sample_q <= sample_data;
        expect_q <= expect_data;
      end
    end
  end

  hier_sat_counter u_pass_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (in_cmp && match),
    .count (pass_count)
  );

  hier_sat_counter u_fail_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (in_cmp && !match),
    .count (fail_count)
  );

`ifdef HIER_CHK_REPORT_EN
  always_ff @(posedge clk) begin
    if (!reset && in_cmp) begin
      if (!match) $write("check %d: got %d expected %d\n", idx, sample_q, expect_q);
      if (last) begin
        if (match && fail_count == 8'd0) $write("PASS\n");
        else $write("FAIL (%d)\n", match ? fail_count : sat_inc(fail_count));
      end
    end
  end
`endif

endmodule

// File: tb/tb_hier_value_checker.sv
// Table-driven scoreboard bench for hier_value_checker (WIDTH=4, NUM_CHECKS=3).
module tb_hier_value_checker;

  logic       clk = 1'b0;
  logic       reset, start, sample_valid, sample_ready;
  logic [3:0] sample_data, expect_data;
  logic [7:0] pass_count, fail_count, first_fail_idx;
  logic       done, pass;

  int errors = 0;
  int checks = 0;

  logic q_match[$];
  int   m_pass, m_fail, m_idx;
  logic [7:0] m_ffi;

  typedef struct {
    logic [2:0][3:0] s;
    logic [2:0][3:0] e;
    logic [7:0]      pc;
    logic [7:0]      fc;
    logic [7:0]      ffi;
    logic            ps;
  } vec_t;
  vec_t tbl[3];

  hier_value_checker #(.WIDTH(4), .NUM_CHECKS(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .sample_data    (sample_data),
    .expect_data    (expect_data),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .first_fail_idx (first_fail_idx),
    .done           (done),
    .pass           (pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pass = 0; m_fail = 0; m_idx = 0; m_ffi = 8'hFF;
    q_match.delete();
    chk("ready_after_start", sample_ready, 1'b1);
  endtask

  // Drive one pair, wait for acceptance, then score the compare result.
  task automatic send(input logic [3:0] s, input logic [3:0] e);
    int n = 0;
    logic em;
    sample_valid = 1'b1;
    sample_data  = s;
    expect_data  = e;
    while (!sample_ready && n < 10) begin
      tick();
      n++;
    end
    if (n == 10) chk("ready_timeout", 1'b0, 1'b1);
    tick();
    sample_valid = 1'b0;
    q_match.push_back((s === e) && !$isunknown(s) && !$isunknown(e));
    chk("ready_low_in_cmp", sample_ready, 1'b0);
    tick();
    em = q_match.pop_front();
    if (em) m_pass++;
    else begin
      m_fail++;
      if (m_ffi == 8'hFF) m_ffi = 8'(m_idx);
    end
    m_idx++;
    chk("pass_count", pass_count, 32'(m_pass));
    chk("fail_count", fail_count, 32'(m_fail));
    chk("first_fail_idx", first_fail_idx, m_ffi);
    chk("done", done, m_idx == 3);
  endtask

  initial begin
    tbl[0] = '{s: {4'd5, 4'd9, 4'd9}, e: {4'd5, 4'd9, 4'd9}, pc: 8'd3, fc: 8'd0, ffi: 8'hFF, ps: 1'b1};
    tbl[1] = '{s: {4'd5, 4'd4, 4'd9}, e: {4'd6, 4'd9, 4'd9}, pc: 8'd1, fc: 8'd2, ffi: 8'd1,  ps: 1'b0};
    tbl[2] = '{s: {4'hA, 4'hF, 4'h0}, e: {4'h5, 4'hF, 4'hF}, pc: 8'd1, fc: 8'd2, ffi: 8'd0,  ps: 1'b0};

    reset = 1'b1; start = 1'b1; sample_valid = 1'b0; sample_data = '0; expect_data = '0;
    tick();
    tick();
    // reset held with start asserted: reset has priority
    chk("rst_ready", sample_ready, 1'b0);
    chk("rst_pass_count", pass_count, 8'd0);
    chk("rst_fail_count", fail_count, 8'd0);
    chk("rst_ffi", first_fail_idx, 8'hFF);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("idle_ready", sample_ready, 1'b0);

    for (int v = 0; v < 3; v++) begin
      do_start();
      for (int p = 0; p < 3; p++) send(tbl[v].s[p], tbl[v].e[p]);
      chk("vec_pass_count", pass_count, tbl[v].pc);
      chk("vec_fail_count", fail_count, tbl[v].fc);
      chk("vec_ffi", first_fail_idx, tbl[v].ffi);
      chk("vec_pass", pass, tbl[v].ps);
      tick();
      chk("vec_done_held", done, 1'b1);
    end

    // Unknown bit on the sample side; expectations come from the driven value
    do_start();
    send(4'b1x01, 4'b1001);
    send(4'd3, 4'd3);
    send(4'd7, 4'd7);
    chk("x_pass", pass, m_fail == 0);

    // Continuous valid: one acceptance per two cycles, done on cycle 6
    start = 1'b1; sample_valid = 1'b1; sample_data = 4'd3; expect_data = 4'd3;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("stream_ready", sample_ready, (k % 2 == 0) && k < 6);
      chk("stream_done", done, k == 6);
    end
    sample_valid = 1'b0;
    chk("stream_pass_count", pass_count, 8'd3);
    chk("stream_pass", pass, 1'b1);

    // Abort during CMP: in-flight mismatch must never be counted
    do_start();
    sample_valid = 1'b1; sample_data = 4'd1; expect_data = 4'd2;
    tick();
    sample_valid = 1'b0;
    chk("abort_in_cmp", sample_ready, 1'b0);
    do_start();
    tick();
    chk("abort_fail_count", fail_count, 8'd0);
    chk("abort_ffi", first_fail_idx, 8'hFF);
    for (int p = 0; p < 3; p++) send(4'd2, 4'd2);
    chk("abort_pass", pass, 1'b1);

    // Reset mid-run
    do_start();
    send(4'd1, 4'd2);
    reset = 1'b1;
    tick();
    chk("midrst_ready", sample_ready, 1'b0);
    chk("midrst_pass_count", pass_count, 8'd0);
    chk("midrst_fail_count", fail_count, 8'd0);
    chk("midrst_ffi", first_fail_idx, 8'hFF);
    chk("midrst_done", done, 1'b0);
    chk("midrst_pass", pass, 1'b0);
    reset = 1'b0;
    sample_valid = 1'b1;
    tick();
    tick();
    chk("midrst_idle", sample_ready, 1'b0);
    sample_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
